posit_round_encode_pipe: RTL and testbench

- Pipelined, multi-lane posit encoder with rounding.
- Takes unpacked posits (sign, biased exponent, fraction) plus extra low-order fraction bits and a sticky bit, and produces WIDTH-bit packed posits.
- Rounds round-to-nearest-even, or truncates, with posit saturation semantics.
- Sits at the output of the posit add/multiply datapaths, replacing the combinational truncating encoder on paths that carry guard bits. Uses a valid/ready stream interface.

---
 rtl/posit_round_encode_pipe.sv | 171 +++++++++++++++++
 tb/tb_posit_round_encode_pipe.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_round_encode_pipe.sv
// posit_round_encode_pipe
//   Two-stage, multi-lane posit encoder with round-to-nearest-even (or
//   truncation) and posit saturation. Input beats carry an unpacked posit
//   (sign, biased exponent, fraction) plus trailing guard bits and a sticky
//   bit. Output beats carry WIDTH-bit packed sign-magnitude posits.
//
// Ports
//   clock, resetn          : clock, synchronous active-low reset
//   in_valid / in_ready    : input stream handshake
//   in_sign, in_exponent,
//   in_fraction,
//   in_trailing, in_sticky : per-lane unpacked operands
//   in_isZero, in_isInf    : per-lane special-value flags (zero wins)
//   out_valid / out_ready  : output stream handshake
//   out_data               : packed posits, lane k at [k*WIDTH +: WIDTH]
module posit_round_encode_pipe #(
  parameter int WIDTH      = 8,
  parameter int ES         = 1,
  parameter int LANES      = 1,
  parameter int TRAIL_BITS = 3,
  parameter int ROUND      = 1,
  localparam int FB        = WIDTH - 3 - ES,
  localparam int MAXU      = 2 * (WIDTH - 2),
  localparam int RW        = $clog2(MAXU + 1),
  localparam int EB        = RW + ES
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES-1:0]              in_sign,
  input  logic [LANES*EB-1:0]           in_exponent,
  input  logic [LANES*FB-1:0]           in_fraction,
  input  logic [LANES*TRAIL_BITS-1:0]   in_trailing,
  input  logic [LANES-1:0]              in_sticky,
  input  logic [LANES-1:0]              in_isZero,
  input  logic [LANES-1:0]              in_isInf,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*WIDTH-1:0]        out_data
);

  localparam int TW = WIDTH - 1;             // magnitude window width
  localparam int TL = ES + FB + TRAIL_BITS;  // bits following the regime
  localparam int ML = WIDTH + TL;            // regime is at most WIDTH bits long

  logic                   s1_valid_q, s1_valid_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [LANES-1:0]       s1_sign_q, s1_sign_d;
  logic [LANES-1:0]       s1_g_q, s1_g_d;
  logic [LANES-1:0]       s1_s_q, s1_s_d;
  logic [LANES-1:0]       s1_zero_q, s1_zero_d;
  logic [LANES-1:0]       s1_inf_q, s1_inf_d;
  logic [LANES*TW-1:0]    s1_t_q, s1_t_d;
  logic [LANES*WIDTH-1:0] out_data_q, out_data_d;

  logic                   s1_adv, s2_adv, in_fire;
  logic [LANES*TW-1:0]    t_all;
  logic [LANES-1:0]       g_all, s_all;
  logic [LANES*WIDTH-1:0] res_all;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [EB-1:0]    exp_l;
    logic [RW-1:0]    ureg, ureg_c;
    logic [TL-1:0]    tail;
    logic [ML-1:0]    regime, m;
    int               rl;
    logic [TW-1:0]    t_r;
    logic             round_up;
    logic [WIDTH-1:0] res_l;

    assign exp_l = in_exponent[k*EB +: EB];
    assign ureg  = exp_l[EB-1:ES];

    if (ES > 0) begin : g_es
      assign tail = {exp_l[ES-1:0], in_fraction[k*FB +: FB],
                     in_trailing[k*TRAIL_BITS +: TRAIL_BITS]};
    end else begin : g_no_es
      assign tail = {in_fraction[k*FB +: FB],
                     in_trailing[k*TRAIL_BITS +: TRAIL_BITS]};
    end

    // M is built MSB-aligned in an ML-bit word: regime run plus terminator,
    // then the tail shifted down by the regime length.
    always_comb begin
      ureg_c = (ureg > RW'(MAXU)) ? RW'(MAXU) : ureg;
      if (ureg_c >= RW'(WIDTH - 2)) begin
        rl     = int'(ureg_c) - (WIDTH - 2) + 2;
        regime = ~({ML{1'b1}} >> (rl - 1));
      end else begin
        rl     = (WIDTH - 2) - int'(ureg_c) + 1;
        regime = {1'b1, {(ML-1){1'b0}}} >> (rl - 1);
      end
      m = regime | ({tail, {WIDTH{1'b0}}} >> rl);
    end

    assign t_all[k*TW +: TW] = m[ML-1 -: TW];
    assign g_all[k]          = m[ML-1-TW];
    assign s_all[k]          = (|m[ML-2-TW:0]) | in_sticky[k];

    // All-ones T is maxpos: rounding there would carry into the sign bit.
    assign t_r      = s1_t_q[k*TW +: TW];
    assign round_up = (ROUND != 0) && s1_g_q[k] && (s1_s_q[k] || t_r[0]) && !(&t_r);

    always_comb begin
      if (s1_zero_q[k]) begin
        res_l = '0;
      end else if (s1_inf_q[k]) begin
        res_l = {1'b1, {TW{1'b0}}};
      end else begin
        res_l = {s1_sign_q[k], t_r + TW'(round_up)};
      end
    end

    assign res_all[k*WIDTH +: WIDTH] = res_l;
  end

  always_comb begin
    s2_adv  = !s2_valid_q || out_ready;
    s1_adv  = !s1_valid_q || s2_adv;
    in_fire = in_valid && s1_adv;

    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_t_d     = s1_t_q;
    s1_g_d     = s1_g_q;
    s1_s_d     = s1_s_q;
    s1_zero_d  = s1_zero_q;
    s1_inf_d   = s1_inf_q;
    if (in_fire) begin
      s1_sign_d = in_sign;
      s1_t_d    = t_all;
      s1_g_d    = g_all;
      s1_s_d    = s_all;
      s1_zero_d = in_isZero;
      s1_inf_d  = in_isInf;
    end

    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    out_data_d = (s2_adv && s1_valid_q) ? res_all : out_data_q;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_sign_q  <= '0;
      s1_t_q     <= '0;
      s1_g_q     <= '0;
      s1_s_q     <= '0;
      s1_zero_q  <= '0;
      s1_inf_q   <= '0;
      out_data_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_t_q     <= s1_t_d;
      s1_g_q     <= s1_g_d;
      s1_s_q     <= s1_s_d;
      s1_zero_q  <= s1_zero_d;
      s1_inf_q   <= s1_inf_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_posit_round_encode_pipe.sv
// Testbench for posit_round_encode_pipe: a rounding instance (WIDTH=8, ES=1,
// LANES=2, TRAIL_BITS=3) and a truncating single-lane instance.
module tb_posit_round_encode_pipe;

  typedef struct packed {
    logic       sgn;
    logic [4:0] exp;
    logic [3:0] frac;
    logic [2:0] trail;
    logic       sticky;
    logic       zero;
    logic       inf;
  } lane_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready;
  logic [1:0]  in_sign, in_sticky, in_isZero, in_isInf;
  logic [9:0]  in_exponent;
  logic [7:0]  in_fraction;
  logic [5:0]  in_trailing;
  logic        out_valid, out_ready;
  logic [15:0] out_data;

  logic        t_in_valid, t_in_ready;
  logic [0:0]  t_sign, t_sticky, t_zero, t_inf;
  logic [4:0]  t_exponent;
  logic [3:0]  t_fraction;
  logic [2:0]  t_trailing;
  logic        t_out_valid;
  logic        t_out_ready;
  logic [7:0]  t_out_data;

  int tests_run = 0;
  int tests_failed = 0;
  logic [15:0] exp_q[$];
  int n_acc, n_out;

  always #5 clock = ~clock;

  posit_round_encode_pipe #(.WIDTH(8), .ES(1), .LANES(2), .TRAIL_BITS(3), .ROUND(1)) u_dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exponent(in_exponent), .in_fraction(in_fraction),
    .in_trailing(in_trailing), .in_sticky(in_sticky),
    .in_isZero(in_isZero), .in_isInf(in_isInf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  posit_round_encode_pipe #(.WIDTH(8), .ES(1), .LANES(1), .TRAIL_BITS(3), .ROUND(0)) u_trunc (
    .clock(clock), .resetn(resetn),
    .in_valid(t_in_valid), .in_ready(t_in_ready),
    .in_sign(t_sign), .in_exponent(t_exponent), .in_fraction(t_fraction),
    .in_trailing(t_trailing), .in_sticky(t_sticky),
    .in_isZero(t_zero), .in_isInf(t_inf),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_data(t_out_data)
  );

  // Reference: spell out the magnitude bit string as a list, take the first
  // seven bits, the guard and the OR of the rest, then round on integers.
  function automatic logic [7:0] model(input lane_t x, input bit rnd);
    int bits[$];
    int u, r, t, g, s;
    if (x.zero) return 8'h00;
    if (x.inf) return 8'h80;
    u = int'(x.exp) / 2;
    if (u > 12) u = 12;
    r = u - 6;
    if (r >= 0) begin
      for (int i = 0; i < r + 1; i++) bits.push_back(1);
      bits.push_back(0);
    end else begin
      for (int i = 0; i < -r; i++) bits.push_back(0);
      bits.push_back(1);
    end
    bits.push_back(int'(x.exp % 2));
    for (int i = 3; i >= 0; i--) bits.push_back(int'(x.frac[i]));
    for (int i = 2; i >= 0; i--) bits.push_back(int'(x.trail[i]));
    t = 0;
    for (int i = 0; i < 7; i++) t = t * 2 + bits[i];
    g = bits[7];
    s = int'(x.sticky);
    for (int i = 8; i < bits.size(); i++) s = s | bits[i];
    if (rnd && g == 1 && (s == 1 || t % 2 == 1) && t != 127) t = t + 1;
    return {x.sgn, 7'(t)};
  endfunction

  function automatic lane_t mk(input int sgn, input int e, input int f, input int tr,
                               input int st, input int z, input int inf);
    lane_t x;
    x.sgn = 1'(sgn); x.exp = 5'(e); x.frac = 4'(f); x.trail = 3'(tr);
    x.sticky = 1'(st); x.zero = 1'(z); x.inf = 1'(inf);
    return x;
  endfunction

  function automatic lane_t rand_lane();
    lane_t x;
    x.sgn    = 1'($urandom);
    x.exp    = 5'($urandom);
    x.frac   = 4'($urandom);
    x.trail  = 3'($urandom);
    x.sticky = 1'($urandom);
    x.zero   = ($urandom_range(0, 7) == 0);
    x.inf    = ($urandom_range(0, 7) == 0);
    return x;
  endfunction

  task automatic drive_lanes(input lane_t a, input lane_t b);
    in_sign     = {b.sgn, a.sgn};
    in_exponent = {b.exp, a.exp};
    in_fraction = {b.frac, a.frac};
    in_trailing = {b.trail, a.trail};
    in_sticky   = {b.sticky, a.sticky};
    in_isZero   = {b.zero, a.zero};
    in_isInf    = {b.inf, a.inf};
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    t_in_valid = 1'b0; t_out_ready = 1'b1;
    drive_lanes('0, '0);
    t_sign = '0; t_exponent = '0; t_fraction = '0; t_trailing = '0;
    t_sticky = '0; t_zero = '0; t_inf = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++;
    if (out_data !== 16'h0) begin tests_failed++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    resetn = 1'b1;
    @(negedge clock);
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    lane_t da[8], db[8];
    logic [7:0] ea[8], eb[8];
    da[0] = mk(0, 12, 0, 0, 0, 0, 0);  ea[0] = 8'h40;
    db[0] = mk(1, 13, 8, 0, 0, 0, 0);  eb[0] = 8'hD8;
    da[1] = mk(0, 12, 1, 4, 0, 0, 0);  ea[1] = 8'h42;
    db[1] = mk(0, 12, 0, 4, 0, 0, 0);  eb[1] = 8'h40;
    da[2] = mk(0, 12, 0, 4, 1, 0, 0);  ea[2] = 8'h41;
    db[2] = mk(0, 25, 15, 7, 0, 0, 0); eb[2] = 8'h7F;
    da[3] = mk(0, 31, 0, 0, 0, 0, 0);  ea[3] = 8'h7F;
    db[3] = mk(0, 1, 0, 0, 0, 0, 0);   eb[3] = 8'h02;
    da[4] = mk(0, 0, 0, 7, 0, 0, 0);   ea[4] = 8'h01;
    db[4] = mk(1, 12, 0, 0, 0, 1, 0);  eb[4] = 8'h00;
    da[5] = mk(1, 12, 0, 0, 0, 0, 1);  ea[5] = 8'h80;
    db[5] = mk(1, 5, 3, 2, 1, 1, 1);   eb[5] = 8'h00;
    da[6] = mk(1, 11, 8, 0, 0, 0, 0);  ea[6] = 8'hB8;
    db[6] = mk(0, 6, 10, 5, 0, 0, 0);  eb[6] = 8'h0B;
    da[7] = mk(0, 0, 0, 0, 1, 0, 0);   ea[7] = 8'h01;
    db[7] = mk(0, 25, 15, 7, 1, 0, 0); eb[7] = 8'h7F;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      drive_lanes(da[i], db[i]);
      in_valid = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL dir%0d_in_ready got %b want 1", i, in_ready); end
      @(negedge clock);
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL dir%0d_early_valid got %b want 0", i, out_valid); end
      @(negedge clock);
      tests_run++;
      if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL dir%0d_latency out_valid got %b want 1", i, out_valid); end
      tests_run++;
      if (out_data !== {eb[i], ea[i]})
        begin tests_failed++; $display("FAIL dir%0d_data got %h want %h", i, out_data, {eb[i], ea[i]}); end
    end
    @(negedge clock);
  endtask

  // mode 0: back-to-back, always ready; 1: ready pattern 1,0,0,1,0,1;
  // 2: random ready and random input gaps.
  task automatic test_stream(input int n, input int mode);
    n_acc = 0; n_out = 0;
    exp_q.delete();
    fork
      begin : driver
        lane_t a, b;
        bit acc;
        int guard;
        @(negedge clock);
        for (int i = 0; i < n; i++) begin
          if (mode == 2 && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            @(negedge clock);
          end
          a = rand_lane(); b = rand_lane();
          drive_lanes(a, b);
          in_valid = 1'b1;
          acc = 1'b0; guard = 0;
          while (!acc && guard < 200) begin
            #3;
            if (in_ready === 1'b1) begin
              exp_q.push_back({model(b, 1'b1), model(a, 1'b1)});
              n_acc++;
              acc = 1'b1;
            end
            @(negedge clock);
            guard++;
          end
        end
        in_valid = 1'b0;
      end
      begin : monitor
        int cyc;
        bit stalled;
        logic [15:0] held, want;
        bit pat[6];
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1;
        cyc = 0; stalled = 0; held = '0;
        while (n_out < n && cyc < 40 + 12 * n) begin
          @(negedge clock);
          out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 6] : 1'($urandom);
          #2;
          tests_run++;
          if (in_ready !== !((n_acc - n_out) == 2 && !out_ready)) begin
            tests_failed++;
            $display("FAIL stream%0d_in_ready cyc %0d got %b occ %0d out_ready %b", mode, cyc, in_ready, n_acc - n_out, out_ready);
          end
          #1;
          if (stalled) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== held) begin
              tests_failed++;
              $display("FAIL stream%0d_stall_hold got %b/%h want 1/%h", mode, out_valid, out_data, held);
            end
          end
          stalled = (out_valid === 1'b1) && !out_ready;
          held = out_data;
          if (out_valid === 1'b1 && out_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
              tests_failed++;
              $display("FAIL stream%0d_extra_beat got %h want none", mode, out_data);
            end else begin
              want = exp_q.pop_front();
              if (out_data !== want) begin
                tests_failed++;
                $display("FAIL stream%0d_beat%0d got %h want %h", mode, n_out, out_data, want);
              end
            end
            n_out++;
          end
          cyc++;
        end
        tests_run++;
        if (n_out != n) begin
          tests_failed++;
          $display("FAIL stream%0d_timeout got %0d beats want %0d", mode, n_out, n);
        end
      end
    join
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clock);
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream%0d_drain got valid %b want 0", mode, out_valid); end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clock);
    out_ready = 1'b0;
    drive_lanes(rand_lane(), rand_lane());
    in_valid = 1'b1;
    @(negedge clock);
    drive_lanes(rand_lane(), rand_lane());
    @(negedge clock);
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL midrst_full_in_ready got %b want 0", in_ready); end
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    tests_run++;
    if (out_data !== 16'h0) begin tests_failed++; $display("FAIL midrst_out_data got %h want 0000", out_data); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clock);
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_stale_beat got valid %b want 0", out_valid); end
    end
  endtask

  task automatic test_truncate();
    lane_t x;
    logic [7:0] want;
    for (int i = 0; i < 26; i++) begin
      case (i)
        0: begin x = mk(0, 12, 1, 7, 0, 0, 0); want = 8'h41; end
        1: begin x = mk(0, 12, 1, 4, 1, 0, 0); want = 8'h41; end
        2: begin x = mk(1, 25, 15, 7, 1, 0, 0); want = 8'hFF; end
        default: begin x = rand_lane(); want = model(x, 1'b0); end
      endcase
      @(negedge clock);
      t_sign = x.sgn; t_exponent = x.exp; t_fraction = x.frac; t_trailing = x.trail;
      t_sticky = x.sticky; t_zero = x.zero; t_inf = x.inf;
      t_in_valid = 1'b1;
      @(negedge clock);
      t_in_valid = 1'b0;
      @(negedge clock);
      tests_run++;
      if (t_out_valid !== 1'b1 || t_out_data !== want) begin
        tests_failed++;
        $display("FAIL trunc%0d got %b/%h want 1/%h", i, t_out_valid, t_out_data, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream(20, 0);
    test_stream(5, 1);
    test_stream(15, 1);
    test_stream(80, 2);
    test_reset_midflight();
    test_truncate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "timeout");
  end

endmodule
